vec_normalize_seq: RTL and testbench

Parametrised, multi-cycle successor to the combinational 2-D direction normaliser. It scales a signed 2-D or 3-D integer vector to length `d` (out_c = trunc(c·d / ⌊|v|⌋)) using a shared bit-serial integer square root and restoring divider, so no wide combinational multiply/divide is needed. It sits between ray-direction generation and the tracer core, with valid/ready handshakes on both sides.

---
 rtl/vec_norm_pkg.sv | 29 ++
 rtl/vn_seq_divider.sv | 93 +++++++++
 rtl/vec_normalize_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_vec_normalize_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_norm_pkg.sv
// Shared types and sizing helpers for the sequential vector normaliser.
package vec_norm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUMSQ,
    SQRT,
    DIV_X,
    DIV_Y,
    DIV_Z,
    DONE
  } vn_state_t;

  // Width of the sum of squares.
  function automatic int vn_sw(input int width);
    return 2 * width;
  endfunction

  // Numerator width |c|*d and cycles per component divide.
  function automatic int vn_n(input int width, input int dw);
    return width - 1 + dw;
  endfunction

  // Accept-to-valid latency in cycles.
  function automatic int vn_lat(input int width, input int dw, input bit mode3d);
    return 1 + width + (mode3d ? 3 : 2) * vn_n(width, dw);
  endfunction

endpackage

// File: rtl/vn_seq_divider.sv
// Restoring divider, one quotient bit per cycle; the start cycle performs the first step,
// so an NW-bit divide spans exactly NW cycles and done_o flags the final one.
module vn_seq_divider #(
  parameter int NW  = 18,
  parameter int DVW = 11,
  parameter int QW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [NW-1:0]  numer_i,
  input  logic [DVW-1:0] denom_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [QW-1:0]  quot_o
);

  localparam int CW = $clog2(NW + 1);

  logic [NW-1:0]  num_q, num_d;
  logic [QW-1:0]  quo_q, quo_d;
  logic [DVW-1:0] rem_q, rem_d;
  logic [DVW-1:0] den_q, den_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;

  logic           go;
  logic           bit_in;
  logic [DVW-1:0] rem_src;
  logic [DVW-1:0] den_src;
  logic [DVW:0]   trial;
  logic           qbit;
  logic [DVW-1:0] rem_step;

  always_comb begin
    go       = start_i && !busy_q;
    rem_src  = go ? '0 : rem_q;
    den_src  = go ? denom_i : den_q;
    bit_in   = go ? numer_i[NW-1] : num_q[NW-1];
    trial    = {rem_src, bit_in};
    qbit     = (trial >= {1'b0, den_src});
    rem_step = qbit ? DVW'(trial - {1'b0, den_src}) : trial[DVW-1:0];
  end

  // Only the low QW quotient bits are kept; callers guarantee the quotient fits.
  always_comb begin
    num_d  = num_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (go) begin
      num_d  = {numer_i[NW-2:0], 1'b0};
      den_d  = denom_i;
      rem_d  = rem_step;
      quo_d  = {{(QW-1){1'b0}}, qbit};
      cnt_d  = CW'(NW - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      num_d = {num_q[NW-2:0], 1'b0};
      rem_d = rem_step;
      quo_d = {quo_q[QW-2:0], qbit};
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      num_q  <= num_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(1));
  assign quot_o = {quo_q[QW-2:0], qbit};

endmodule

// File: rtl/vec_normalize_seq.sv
// Sequential vector normaliser: out_c = trunc(c*d / floor(|v|)) via bit-serial sqrt and a
// time-shared divider. Handshake: a transfer happens on any edge where valid && ready.
module vec_normalize_seq
  import vec_norm_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode3d,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  input  logic [DW-1:0]    in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW:0]      out_x,
  output logic [DW:0]      out_y,
  output logic [DW:0]      out_z,
  output logic             out_zero,
  output vn_state_t        dbg_state
);

  localparam int SW   = vn_sw(WIDTH);
  localparam int N    = vn_n(WIDTH, DW);
  localparam int SRW  = WIDTH + 2;
  localparam int CNTW = $clog2(WIDTH + 1);

  vn_state_t state_q, state_d;

  logic             mode3d_q, mode3d_d;
  logic             sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [WIDTH-1:0] ax_q, ax_d, ay_q, ay_d, az_q, az_d;
  logic [DW-1:0]    d_q, d_d;
  logic [SW-1:0]    s_q, s_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [SRW-1:0]   srem_q, srem_d;
  logic [CNTW-1:0]  scnt_q, scnt_d;
  logic             zero_q, zero_d;
  logic [DW-1:0]    qx_q, qx_d, qy_q, qy_d;
  logic [DW:0]      ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic             oz_flag_q, oz_flag_d;

  logic [SW-1:0]    sq_x, sq_y, sq_z, s_sum;
  logic [SRW+1:0]   rem_sh, trial_sq;
  logic [WIDTH-1:0] abs_sel;
  logic             div_start, div_busy, div_done;
  logic [N-1:0]     div_num;
  logic [DW-1:0]    div_quot, q_eff;

  function automatic logic [WIDTH-1:0] abs_c(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [DW:0] apply_sign(input logic [DW-1:0] mag, input logic neg);
    return neg ? (~{1'b0, mag} + (DW+1)'(1)) : {1'b0, mag};
  endfunction

  // Sequencing: divide states advance on the divider's final-step flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SUMSQ;
      SUMSQ:   state_d = SQRT;
      SQRT:    if (scnt_q == CNTW'(WIDTH - 1)) state_d = DIV_X;
      DIV_X:   if (div_done) state_d = DIV_Y;
      DIV_Y:   if (div_done) state_d = mode3d_q ? DIV_Z : DONE;
      DIV_Z:   if (div_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    abs_sel = ax_q;
    case (state_q)
      DIV_Y:   abs_sel = ay_q;
      DIV_Z:   abs_sel = az_q;
      default: abs_sel = ax_q;
    endcase
    div_start = ((state_q == DIV_X) || (state_q == DIV_Y) || (state_q == DIV_Z)) && !div_busy;
    div_num   = N'(abs_sel) * N'(d_q);
    q_eff     = zero_q ? '0 : div_quot;
  end

  vn_seq_divider #(
    .NW (N),
    .DVW(WIDTH),
    .QW (DW)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .start_i(div_start),
    .numer_i(div_num),
    .denom_i(root_q),
    .busy_o (div_busy),
    .done_o (div_done),
    .quot_o (div_quot)
  );

  always_comb begin
    mode3d_d  = mode3d_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    sz_d      = sz_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    az_d      = az_q;
    d_d       = d_q;
    s_d       = s_q;
    root_d    = root_q;
    srem_d    = srem_q;
    scnt_d    = scnt_q;
    zero_d    = zero_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    ox_d      = ox_q;
    oy_d      = oy_q;
    oz_d      = oz_q;
    oz_flag_d = oz_flag_q;

    sq_x     = SW'(ax_q) * SW'(ax_q);
    sq_y     = SW'(ay_q) * SW'(ay_q);
    sq_z     = SW'(az_q) * SW'(az_q);
    s_sum    = sq_x + sq_y + sq_z;
    rem_sh   = {srem_q, s_q[SW-1 -: 2]};
    trial_sq = {2'b00, root_q, 2'b01};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode3d_d = in_mode3d;
          sx_d     = in_x[WIDTH-1];
          sy_d     = in_y[WIDTH-1];
          sz_d     = in_mode3d && in_z[WIDTH-1];
          ax_d     = abs_c(in_x);
          ay_d     = abs_c(in_y);
          az_d     = in_mode3d ? abs_c(in_z) : '0;
          d_d      = in_d;
        end
      end
      SUMSQ: begin
        s_d    = s_sum;
        zero_d = (s_sum == '0);
        root_d = '0;
        srem_d = '0;
        scnt_d = '0;
      end
      SQRT: begin
        // Restoring square root: two radicand bits in, one root bit out per cycle.
        if (rem_sh >= trial_sq) begin
          srem_d = SRW'(rem_sh - trial_sq);
          root_d = {root_q[WIDTH-2:0], 1'b1};
        end else begin
          srem_d = rem_sh[SRW-1:0];
          root_d = {root_q[WIDTH-2:0], 1'b0};
        end
        s_d    = {s_q[SW-3:0], 2'b00};
        scnt_d = scnt_q + CNTW'(1);
      end
      DIV_X: begin
        if (div_done) qx_d = q_eff;
      end
      DIV_Y: begin
        if (div_done) begin
          if (mode3d_q) begin
            qy_d = q_eff;
          end else begin
            ox_d      = apply_sign(qx_q, sx_q);
            oy_d      = apply_sign(q_eff, sy_q);
            oz_d      = '0;
            oz_flag_d = zero_q;
          end
        end
      end
      DIV_Z: begin
        if (div_done) begin
          ox_d      = apply_sign(qx_q, sx_q);
          oy_d      = apply_sign(qy_q, sy_q);
          oz_d      = apply_sign(q_eff, sz_q);
          oz_flag_d = zero_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode3d_q  <= 1'b0;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      sz_q      <= 1'b0;
      ax_q      <= '0;
      ay_q      <= '0;
      az_q      <= '0;
      d_q       <= '0;
      s_q       <= '0;
      root_q    <= '0;
      srem_q    <= '0;
      scnt_q    <= '0;
      zero_q    <= 1'b0;
      qx_q      <= '0;
      qy_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      oz_q      <= '0;
      oz_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode3d_q  <= mode3d_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      sz_q      <= sz_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      az_q      <= az_d;
      d_q       <= d_d;
      s_q       <= s_d;
      root_q    <= root_d;
      srem_q    <= srem_d;
      scnt_q    <= scnt_d;
      zero_q    <= zero_d;
      qx_q      <= qx_d;
      qy_q      <= qy_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      oz_q      <= oz_d;
      oz_flag_q <= oz_flag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_z     = oz_q;
  assign out_zero  = oz_flag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vec_normalize_seq.sv
// Randomised and directed bench for vec_normalize_seq against an arithmetic reference model.
`timescale 1ns/1ps
module tb_vec_normalize_seq;
  import vec_norm_pkg::*;

  localparam int WIDTH = 11;
  localparam int DW    = 8;
  localparam int N     = WIDTH - 1 + DW;
  localparam int LAT2  = 1 + WIDTH + 2 * N;
  localparam int LAT3  = 1 + WIDTH + 3 * N;
  localparam int RW    = 1 + 3 * (DW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_mode3d;
  logic [WIDTH-1:0] in_x, in_y, in_z;
  logic [DW-1:0]    in_d;
  logic             out_valid;
  logic             out_ready;
  logic [DW:0]      out_x, out_y, out_z;
  logic             out_zero;
  vn_state_t        dbg_state;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  vec_normalize_seq #(.WIDTH(WIDTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode3d(in_mode3d),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_d(in_d), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_zero(out_zero), .dbg_state(dbg_state)
  );

  // Reference model: plain integer arithmetic on the mathematical definition.
  function automatic logic [DW:0] comp(input int c, input int d, input longint m);
    longint q;
    int     v;
    q = (c < 0 ? -longint'(c) : longint'(c)) * d / m;
    v = (c < 0) ? -int'(q) : int'(q);
    return v[DW:0];
  endfunction

  function automatic logic [RW-1:0] model(input bit m3, input int x, input int y, input int z,
                                          input int d);
    longint s, m;
    int     zz;
    zz = m3 ? z : 0;
    s  = longint'(x) * x + longint'(y) * y + longint'(zz) * zz;
    if (s == 0) return {1'b1, {(3*(DW+1)){1'b0}}};
    m = 0;
    while ((m + 1) * (m + 1) <= s) m++;
    return {1'b0, comp(x, d, m), comp(y, d, m), m3 ? comp(z, d, m) : {(DW+1){1'b0}}};
  endfunction

  task automatic garble();
    in_x      = WIDTH'($urandom);
    in_y      = WIDTH'($urandom);
    in_z      = WIDTH'($urandom);
    in_d      = DW'($urandom);
    in_mode3d = 1'($urandom);
  endtask

  // Drives a request, waits (bounded) for in_ready, returns #1 after the accept edge.
  task automatic send(input bit m3, input int x, input int y, input int z, input int d);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    in_mode3d = m3;
    in_x      = x[WIDTH-1:0];
    in_y      = y[WIDTH-1:0];
    in_z      = z[WIDTH-1:0];
    in_d      = d[DW-1:0];
    exp_q.push_back(model(m3, x, y, z, d));
    lat_q.push_back(m3 ? LAT3 : LAT2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    garble();
  endtask

  task automatic wait_result(input string tag);
    int            lat, exp_lat;
    logic [RW-1:0] exp, got;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    exp     = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b after %0d cycles, required 1", tag, out_valid, lat);
    end else if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
    end
    got = {out_zero, out_x, out_y, out_z};
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s result {zero,x,y,z}: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", tag, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; garble();
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_x, out_y, out_z, out_zero} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b outs=%h required 1/0/0",
               in_ready, out_valid, {out_x, out_y, out_z, out_zero});
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    send(1'b0, 3, 4, 99, 100);       wait_result("2d_3_4");   consume("2d_3_4");
    send(1'b1, 2, -3, 6, 200);       wait_result("3d_2_m3_6"); consume("3d_2_m3_6");
    send(1'b0, -1024, 0, 0, 255);    wait_result("most_neg"); consume("most_neg");
    send(1'b1, 0, 0, 0, 50);         wait_result("zero_3d");  consume("zero_3d");
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] held;
    send(1'b0, 3, 4, 0, 100);
    wait_result("bp");
    held = {out_zero, out_x, out_y, out_z};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; garble();
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_zero, out_x, out_y, out_z} !== held) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b outs=%h required 1/0/%h",
                 i, out_valid, in_ready, {out_zero, out_x, out_y, out_z}, held);
      end
    end
    consume("bp");
  endtask

  task automatic test_reset_mid_sqrt();
    send(1'b1, 100, -200, 300, 77);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {out_x, out_y, out_z, out_zero} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b outs=%h required 1/0/0",
               in_ready, out_valid, {out_x, out_y, out_z, out_zero});
    end
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(1'b0, 3, 4, 0, 100); wait_result("after_reset"); consume("after_reset");
  endtask

  task automatic test_back_to_back();
    send(1'b1, -7, 1, -5, 128);
    wait_result("b2b_a");
    out_ready = 1'b1; in_valid = 1'b1; in_mode3d = 1'b0;
    in_x = 11'd0; in_y = -11'sd5; in_z = 11'd9; in_d = 8'd37;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    exp_q.push_back(model(1'b0, 0, -5, 9, 37));
    lat_q.push_back(LAT2);
    @(posedge clk); #1;
    in_valid = 1'b0; garble();
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: in_ready=%b required 0", in_ready);
    end
    wait_result("b2b_b"); consume("b2b_b");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] rx, ry, rz;
    int hold;
    for (int t = 0; t < 24; t++) begin
      rx = WIDTH'($urandom); ry = WIDTH'($urandom); rz = WIDTH'($urandom);
      if (t % 3 == 0) begin
        rx = WIDTH'($signed(4'($urandom)));
        ry = WIDTH'($signed(4'($urandom)));
        rz = WIDTH'($signed(4'($urandom)));
      end
      send(1'($urandom), int'($signed(rx)), int'($signed(ry)), int'($signed(rz)),
           $urandom_range(0, 255));
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      wait_result("random");
      out_ready = 1'b0;
      hold = $urandom_range(0, 2);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL random_hold: out_valid=%b required 1", out_valid);
        end
      end
      consume("random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_sqrt();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
